// File: rtl/hilo_ctrl_pkg.sv
// hilo_ctrl_pkg: opcode constants, controller state and op-class helper shared by the controller and its ALU.
package hilo_ctrl_pkg;

    localparam logic [4:0] C_ADD_U = 5'd0;
    localparam logic [4:0] C_SUB_U = 5'd1;
    localparam logic [4:0] C_MUL_U = 5'd2;
    localparam logic [4:0] C_MUL_S = 5'd3;
    localparam logic [4:0] C_SLL   = 5'd4;
    localparam logic [4:0] C_SRL   = 5'd5;
    localparam logic [4:0] C_AND   = 5'd6;
    localparam logic [4:0] C_OR    = 5'd7;
    localparam logic [4:0] C_SLT   = 5'd8;
    localparam logic [4:0] C_BEQ   = 5'd9;
    localparam logic [4:0] C_MFHI  = 5'd16;
    localparam logic [4:0] C_MFLO  = 5'd17;

    typedef enum logic [1:0] {IDLE, EXEC, MWAIT, DONE} state_e;
    typedef enum logic [1:0] {CLS_ALU, CLS_MUL, CLS_MOVE, CLS_BAD} op_class_e;

    function automatic op_class_e op_class(input logic [4:0] op);
        return (op inside {C_MUL_U, C_MUL_S}) ? CLS_MUL :
               (op inside {[C_ADD_U:C_BEQ]}) ? CLS_ALU :
               (op inside {C_MFHI, C_MFLO}) ? CLS_MOVE : CLS_BAD;
    endfunction

endpackage

// File: rtl/hilo_ctrl.sv
// hilo_ctrl: request/response sequencer for an external ALU, owning the architectural HI/LO registers.
module hilo_ctrl
    import hilo_ctrl_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic [4:0]       req_shamt,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [4:0]       alu_shamt,
    output logic [4:0]       alu_opsel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [WIDTH-1:0] alu_result_hi,
    input  logic             alu_branch,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_branch,
    output logic             rsp_err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy
);

    localparam logic [3:0] CNT_INIT = 4'(MUL_LAT - 1);

    state_e           state_q;
    logic [3:0]       cnt_q;
    logic [WIDTH-1:0] a_q, b_q, hi_q, lo_q, data_q;
    logic [4:0]       sh_q, op_q;
    logic             br_q, err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sh_q    <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            data_q  <= '0;
            br_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    op_q  <= req_op;
                    a_q   <= req_a;
                    b_q   <= req_b;
                    sh_q  <= req_shamt;
                    br_q  <= 1'b0;
                    err_q <= 1'b0;
                    case (op_class(req_op))
                        CLS_ALU: state_q <= EXEC;
                        CLS_MUL: begin
                            state_q <= MWAIT;
                            cnt_q   <= CNT_INIT;
                        end
                        CLS_MOVE: begin
                            state_q <= DONE;
                            data_q  <= (req_op == C_MFHI) ? hi_q : lo_q;
                        end
                        default: begin
                            state_q <= DONE;
                            data_q  <= '0;
                            err_q   <= 1'b1;
                        end
                    endcase
                end
                EXEC: begin
                    state_q <= DONE;
                    data_q  <= alu_result;
                    br_q    <= (op_q == C_BEQ) && alu_branch;
                end
                // counter parks at zero, so MUL_LAT=1 gives a single MWAIT cycle
                MWAIT: if (cnt_q == '0) begin
                    state_q <= DONE;
                    hi_q    <= alu_result_hi;
                    lo_q    <= alu_result;
                    data_q  <= alu_result;
                end else begin
                    cnt_q <= cnt_q - 4'd1;
                end
                DONE: if (rsp_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rsp_valid  = (state_q == DONE);
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign alu_shamt  = sh_q;
    assign alu_opsel  = op_q;
    assign rsp_data   = data_q;
    assign rsp_branch = br_q;
    assign rsp_err    = err_q;
    assign hi         = hi_q;
    assign lo         = lo_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// tb_hilo_ctrl: two controllers (MUL_LAT=4 and MUL_LAT=1) each driving a behavioural ALU, checked against a transaction-level model.
module tb_hilo_ctrl;
    import hilo_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rsp_ready;
    logic [4:0]  req_op, req_shamt;
    logic [31:0] req_a, req_b;
    logic        req_valid[2];
    logic        req_ready_w[2], rsp_valid_w[2], rsp_branch_w[2], rsp_err_w[2], busy_w[2], alu_br[2];
    logic [31:0] alu_a_w[2], alu_b_w[2], alu_res[2], alu_hi[2], rsp_data_w[2], hi_w[2], lo_w[2];
    logic [4:0]  alu_sh_w[2], alu_op_w[2];

    int checks = 0;
    int errors = 0;
    logic [31:0] mhi[2], mlo[2];

    // ALU stand-in: branch flag raised on equality for every op, so the controller must mask it
    function automatic logic [64:0] alu_model(input logic [4:0] op, input logic [31:0] a, b, input logic [4:0] sh);
        logic [63:0] p;
        logic [31:0] r;
        p = '0;
        case (op)
            C_ADD_U: r = a + b;
            C_SUB_U: r = a - b;
            C_SLL:   r = a << sh;
            C_SRL:   r = a >> sh;
            C_AND:   r = a & b;
            C_OR:    r = a | b;
            C_SLT:   r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            C_BEQ:   r = a - b;
            C_MUL_U: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
            C_MUL_S: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); r = p[31:0]; end
            default: r = 32'hDEAD_BEEF;
        endcase
        return {a == b, (op == C_MUL_U || op == C_MUL_S) ? p[63:32] : 32'hBAD0_0BAD, r};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gd
        hilo_ctrl #(.WIDTH(32), .MUL_LAT(g == 0 ? 4 : 1)) dut (
            .clk(clk), .rst(rst),
            .req_valid(req_valid[g]), .req_ready(req_ready_w[g]),
            .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_shamt(req_shamt),
            .alu_a(alu_a_w[g]), .alu_b(alu_b_w[g]), .alu_shamt(alu_sh_w[g]), .alu_opsel(alu_op_w[g]),
            .alu_result(alu_res[g]), .alu_result_hi(alu_hi[g]), .alu_branch(alu_br[g]),
            .rsp_valid(rsp_valid_w[g]), .rsp_ready(rsp_ready),
            .rsp_data(rsp_data_w[g]), .rsp_branch(rsp_branch_w[g]), .rsp_err(rsp_err_w[g]),
            .hi(hi_w[g]), .lo(lo_w[g]), .busy(busy_w[g])
        );
        assign {alu_br[g], alu_hi[g], alu_res[g]} = alu_model(alu_op_w[g], alu_a_w[g], alu_b_w[g], alu_sh_w[g]);
    end

    // one full transaction; latency counts edges from the acceptance edge (inclusive) to rsp_valid
    task automatic do_txn(input int d, input logic [4:0] op, input logic [31:0] a, b, input logic [4:0] sh,
                          input int stall, output int lat, output logic [31:0] data, output logic br, err,
                          output bit stable, rdy_ok, released);
        req_op = op; req_a = a; req_b = b; req_shamt = sh;
        req_valid[d] = 1'b1; rsp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        req_a = $urandom; req_b = $urandom; req_op = 5'($urandom); req_shamt = 5'($urandom);
        lat = 1; rdy_ok = 1'b1; stable = 1'b1;
        while (!rsp_valid_w[d] && lat < 50) begin
            if (req_ready_w[d] || !busy_w[d]) rdy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        data = rsp_data_w[d]; br = rsp_branch_w[d]; err = rsp_err_w[d];
        repeat (stall) begin
            @(posedge clk); #1;
            if (!rsp_valid_w[d] || rsp_data_w[d] !== data || rsp_branch_w[d] !== br || rsp_err_w[d] !== err) stable = 1'b0;
            if (alu_a_w[d] !== a || alu_b_w[d] !== b || alu_op_w[d] !== op || alu_sh_w[d] !== sh) stable = 1'b0;
            if (req_ready_w[d]) rdy_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        released = !rsp_valid_w[d] && req_ready_w[d] && !busy_w[d];
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            checks++;
            if ({req_ready_w[d], rsp_valid_w[d], busy_w[d]} !== 3'b100) begin
                errors++; $display("FAIL reset_hs[%0d] got rdy/vld/busy=%b want 100", d, {req_ready_w[d], rsp_valid_w[d], busy_w[d]});
            end
            checks++;
            if ({hi_w[d], lo_w[d], rsp_data_w[d], alu_a_w[d], alu_b_w[d], alu_sh_w[d], alu_op_w[d], rsp_branch_w[d], rsp_err_w[d]} !== '0) begin
                errors++; $display("FAIL reset_regs[%0d] got hi=%h lo=%h data=%h a=%h b=%h want all zero", d, hi_w[d], lo_w[d], rsp_data_w[d], alu_a_w[d], alu_b_w[d]);
            end
            mhi[d] = '0; mlo[d] = '0;
        end
    endtask

    task automatic test_add;
        int lat; logic [31:0] data; logic br, err; bit st, rdy, rel;
        do_txn(0, C_ADD_U, 32'd5, 32'd7, 5'd0, 0, lat, data, br, err, st, rdy, rel);
        checks++; if (lat != 2) begin errors++; $display("FAIL add_lat got %0d want 2", lat); end
        checks++; if (data !== 32'd12) begin errors++; $display("FAIL add_data got %h want 0000000c", data); end
        checks++; if ({err, br} !== 2'b00) begin errors++; $display("FAIL add_flags got err/br=%b want 00", {err, br}); end
        checks++; if (!rel || !rdy) begin errors++; $display("FAIL add_handshake got released=%b ready_ok=%b want 1 1", rel, rdy); end
    endtask

    task automatic test_mul;
        int lat; logic [31:0] data; logic br, err; bit st, rdy, rel;
        do_txn(0, C_MUL_U, 32'hFFFF_FFFF, 32'd2, 5'd0, 0, lat, data, br, err, st, rdy, rel);
        checks++; if (lat != 5) begin errors++; $display("FAIL mul_lat got %0d want 5", lat); end
        checks++; if (hi_w[0] !== 32'h1 || lo_w[0] !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mul_hilo got %h/%h want 00000001/fffffffe", hi_w[0], lo_w[0]); end
        checks++; if (data !== 32'hFFFF_FFFE || err !== 1'b0) begin errors++; $display("FAIL mul_data got %h err=%b want fffffffe 0", data, err); end
        mhi[0] = 32'h1; mlo[0] = 32'hFFFF_FFFE;
        do_txn(0, C_MFHI, 32'd0, 32'd0, 5'd0, 0, lat, data, br, err, st, rdy, rel);
        checks++; if (lat != 1 || data !== 32'h1) begin errors++; $display("FAIL mfhi got lat=%0d data=%h want 1 00000001", lat, data); end
        do_txn(0, C_MFLO, 32'd0, 32'd0, 5'd0, 1, lat, data, br, err, st, rdy, rel);
        checks++; if (lat != 1 || data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mflo got lat=%0d data=%h want 1 fffffffe", lat, data); end
    endtask

    task automatic test_beq_stall;
        int lat; logic [31:0] data; logic br, err; bit st, rdy, rel;
        do_txn(0, C_BEQ, 32'd3, 32'd3, 5'd0, 3, lat, data, br, err, st, rdy, rel);
        checks++; if (lat != 2 || br !== 1'b1) begin errors++; $display("FAIL beq got lat=%0d br=%b want 2 1", lat, br); end
        checks++; if (!st) begin errors++; $display("FAIL beq_hold got stable=0 want 1"); end
        checks++; if (!rdy || !rel) begin errors++; $display("FAIL beq_ready got ready_ok=%b released=%b want 1 1", rdy, rel); end
    endtask

    task automatic test_bad_op;
        int lat; logic [31:0] data; logic br, err; bit st, rdy, rel;
        do_txn(0, 5'h1F, 32'h1234, 32'h1234, 5'd3, 2, lat, data, br, err, st, rdy, rel);
        checks++; if ({err, br} !== 2'b10 || data !== 32'd0) begin errors++; $display("FAIL bad_op got err/br=%b data=%h want 10 00000000", {err, br}, data); end
        checks++; if (lat != 1 || !st) begin errors++; $display("FAIL bad_op_timing got lat=%0d stable=%b want 1 1", lat, st); end
        checks++; if (hi_w[0] !== mhi[0] || lo_w[0] !== mlo[0]) begin errors++; $display("FAIL bad_op_hilo got %h/%h want %h/%h", hi_w[0], lo_w[0], mhi[0], mlo[0]); end
    endtask

    task automatic test_reset_abort;
        bit seen = 1'b0;
        req_op = C_MUL_U; req_a = 32'd7; req_b = 32'd9; req_shamt = 5'd0;
        req_valid[0] = 1'b1; rsp_ready = 1'b1;
        @(posedge clk); #1 req_valid[0] = 1'b0;
        seen |= rsp_valid_w[0];
        @(posedge clk); #1 rst = 1'b1;
        seen |= rsp_valid_w[0];
        @(posedge clk); #1 rst = 1'b0;
        seen |= rsp_valid_w[0];
        checks++; if (!req_ready_w[0] || busy_w[0]) begin errors++; $display("FAIL abort_ready got rdy=%b busy=%b want 1 0", req_ready_w[0], busy_w[0]); end
        repeat (6) begin @(posedge clk); #1 seen |= rsp_valid_w[0]; end
        rsp_ready = 1'b0;
        checks++; if (seen) begin errors++; $display("FAIL abort_rsp got rsp_valid=1 want 0"); end
        checks++; if (hi_w[0] !== 32'd0 || lo_w[0] !== 32'd0) begin errors++; $display("FAIL abort_hilo got %h/%h want 0/0", hi_w[0], lo_w[0]); end
        for (int d = 0; d < 2; d++) begin mhi[d] = '0; mlo[d] = '0; end
    endtask

    task automatic test_mul_lat1;
        int lat; logic [31:0] data; logic br, err; bit st, rdy, rel;
        do_txn(1, C_MUL_S, -32'sd3, 32'd4, 5'd0, 0, lat, data, br, err, st, rdy, rel);
        checks++; if (lat != 2) begin errors++; $display("FAIL mul1_lat got %0d want 2", lat); end
        checks++; if (hi_w[1] !== 32'hFFFF_FFFF || lo_w[1] !== 32'hFFFF_FFF4) begin errors++; $display("FAIL mul1_hilo got %h/%h want ffffffff/fffffff4", hi_w[1], lo_w[1]); end
        mhi[1] = 32'hFFFF_FFFF; mlo[1] = 32'hFFFF_FFF4;
    endtask

    task automatic test_random;
        int lat, elat, d, stall, r;
        logic [31:0] data, a, b, edata;
        logic [63:0] p;
        logic [4:0] op, sh;
        logic br, err, ebr, eerr;
        bit st, rdy, rel;
        for (int n = 0; n < 80; n++) begin
            d = int'($urandom_range(0, 1)); stall = int'($urandom_range(0, 3)); r = int'($urandom_range(0, 13));
            op = (r < 10) ? 5'(r) : (r == 10) ? C_MFHI : (r == 11) ? C_MFLO :
                 (r == 12) ? 5'($urandom_range(10, 15)) : 5'($urandom_range(18, 31));
            a = $urandom; b = ($urandom_range(0, 3) == 0) ? a : $urandom; sh = 5'($urandom);
            ebr = 1'b0; eerr = 1'b0;
            if (op == C_MUL_U || op == C_MUL_S) begin
                p = (op == C_MUL_S) ? 64'($signed(a)) * 64'($signed(b)) : 64'(a) * 64'(b);
                mhi[d] = p[63:32]; mlo[d] = p[31:0]; edata = p[31:0];
                elat = (d == 0) ? 5 : 2;
            end else if (op == C_MFHI || op == C_MFLO) begin
                edata = (op == C_MFHI) ? mhi[d] : mlo[d]; elat = 1;
            end else if (op <= C_BEQ) begin
                edata = alu_model(op, a, b, sh) >> 0; elat = 2; ebr = (op == C_BEQ) && (a == b);
            end else begin
                edata = '0; elat = 1; eerr = 1'b1;
            end
            do_txn(d, op, a, b, sh, stall, lat, data, br, err, st, rdy, rel);
            checks++;
            if (lat != elat || data !== edata || br !== ebr || err !== eerr) begin
                errors++; $display("FAIL rand[%0d] dut%0d op=%0d got lat=%0d data=%h br=%b err=%b want lat=%0d data=%h br=%b err=%b", n, d, op, lat, data, br, err, elat, edata, ebr, eerr);
            end
            checks++;
            if (hi_w[d] !== mhi[d] || lo_w[d] !== mlo[d] || !st || !rdy || !rel) begin
                errors++; $display("FAIL rand_state[%0d] dut%0d got hi=%h lo=%h stable=%b ready_ok=%b released=%b want hi=%h lo=%h 1 1 1", n, d, hi_w[d], lo_w[d], st, rdy, rel, mhi[d], mlo[d]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_shamt = '0;
        req_valid[0] = 1'b0; req_valid[1] = 1'b0;
        test_reset();
        test_add();
        test_mul();
        test_beq_stall();
        test_bad_op();
        test_reset_abort();
        test_mul_lat1();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the datapath width of all operand, result and HI/LO signals.
REQ-002 Parameter MUL_LAT, default 4, range 1..15, SHALL set the number of cycles the ALU multiply path is allowed to settle.
REQ-003 Ports SHALL be:
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  5  operation code.
- req_a / req_b  in  WIDTH  operands.
- req_shamt  in  5  shift amount.
- alu_a / alu_b  out  WIDTH  registered operands to the ALU.
- alu_shamt  out  5  registered shift amount to the ALU.
- alu_opsel  out  5  registered ALU opsel.
- alu_result / alu_result_hi  in  WIDTH  ALU outputs.
- alu_branch  in  1  ALU branch_taken.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  WIDTH  result.
- rsp_branch  out  1  captured branch flag.
- rsp_err  out  1  unsupported opcode.
- hi / lo  out  WIDTH  architectural HI/LO registers.
- busy  out  1  high in any state other than IDLE.

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, EXEC, MWAIT and DONE.
REQ-005 req_ready SHALL be 1 only in IDLE, and acceptance SHALL occur on the edge where req_valid && req_ready.
REQ-006 On acceptance, req_op, req_a, req_b and req_shamt SHALL be registered onto alu_opsel, alu_a, alu_b and alu_shamt and held stable until the FSM returns to IDLE.
REQ-007 Single-cycle ALU ops (C_ADD_U, C_SUB_U, C_SLL, C_SRL, C_AND, C_OR, C_SLT, C_BEQ) SHALL follow IDLE->EXEC->DONE, capture alu_result into rsp_data and alu_branch into rsp_branch on the EXEC->DONE edge, and assert rsp_valid 2 cycles after acceptance.
REQ-008 Multiply ops (C_MUL_U, C_MUL_S) SHALL follow IDLE->MWAIT, hold MWAIT for MUL_LAT cycles using a down-counter loaded with MUL_LAT-1, then on exit write hi<=alu_result_hi, lo<=alu_result and rsp_data<=alu_result, with rsp_valid asserted MUL_LAT+1 cycles after acceptance.
REQ-009 C_MFHI and C_MFLO SHALL bypass the ALU, go IDLE->DONE with rsp_data = hi or lo as it stands at the acceptance edge, and assert rsp_valid 1 cycle after acceptance.
REQ-010 Any other opcode SHALL go IDLE->DONE with rsp_err=1, rsp_data=0, rsp_branch=0 and hi/lo unchanged.
REQ-011 rsp_branch SHALL be 0 for every op except C_BEQ.
REQ-012 rsp_err SHALL be 0 for all supported ops.
REQ-013 rsp_valid SHALL be 1 exactly in DONE.
REQ-014 rsp_data, rsp_branch and rsp_err SHALL hold stable while rsp_valid && !rsp_ready.
REQ-015 DONE->IDLE SHALL occur on the edge where rsp_ready=1; back-to-back requests therefore incur a one-cycle IDLE bubble.
REQ-016 hi/lo SHALL change only on MWAIT exit; an MFHI or MFLO issued after a multiply SHALL return that multiply's value.
REQ-017 The counter SHALL never wrap: when MUL_LAT=1, MWAIT SHALL last exactly one cycle.

Reset
REQ-018 While rst=1 at a clock edge, the FSM SHALL go to IDLE, and hi, lo, rsp_data, alu_a, alu_b, alu_shamt, alu_opsel, the counter, rsp_branch and rsp_err SHALL all go to 0.
REQ-019 An in-flight operation SHALL be aborted by reset with no response and no HI/LO write.
REQ-020 In the first cycle after reset deasserts, req_ready SHALL be 1, rsp_valid 0 and busy 0.

Structure
REQ-021 A shared package SHALL define the 5-bit opcode constants: C_ADD_U=0, C_SUB_U=1, C_MUL_U=2, C_MUL_S=3, C_SLL=4, C_SRL=5, C_AND=6, C_OR=7, C_SLT=8, C_BEQ=9, C_MFHI=16, C_MFLO=17.
REQ-022 The package SHALL also define the state enum and the ALU/MUL/MOVE op-class helper function, and the ALU SHALL import the same package.
REQ-023 The block SHALL contain no sub-module; the ALU SHALL be instantiated alongside it by the parent.

Verification
REQ-024 The bench SHALL cover the following directed scenarios:
- ADD a=5, b=7 with rsp_ready=1 -> rsp_valid 2 cycles after acceptance, rsp_data=12, rsp_err=0.
- MUL_U a=0xFFFFFFFF, b=2, MUL_LAT=4 -> rsp_valid 5 cycles after acceptance; hi=0x1, lo=0xFFFFFFFE; then MFHI -> rsp_data=0x1 one cycle after acceptance.
- BEQ a=b=3 with rsp_ready held 0 for 3 cycles -> rsp_valid and rsp_branch=1 held stable until the rsp_ready edge; req_ready=0 throughout.
- opcode 5'h1F -> rsp_err=1, rsp_data=0, hi/lo unchanged.
- rst asserted in the 2nd MWAIT cycle of a MUL -> no rsp_valid; hi=lo=0; req_ready=1 the cycle after rst drops.
- MUL_LAT=1, MUL_S a=-3, b=4 -> hi=0xFFFFFFFF, lo=0xFFFFFFF4, rsp_valid 2 cycles after acceptance.
